// File: rtl/apb_initiator_if.sv
// Request/response and APB bus signals of the APB initiator, grouped as one bundle.
// The master modport is the initiator's view; slave is the view of whoever drives it.
interface apb_initiator_if #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [APB_ADDR_WIDTH-1:0] req_addr_i;
    logic                      req_write_i;
    logic [APB_DATA_WIDTH-1:0] req_wdata_i;

    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
    logic                      rsp_err_o;

    logic                      psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [APB_ADDR_WIDTH-1:0] paddr_o;
    logic [APB_DATA_WIDTH-1:0] pwdata_o;
    logic [APB_DATA_WIDTH-1:0] prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, rsp_ready_i,
        input  prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, rsp_ready_i,
        output prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface

// File: rtl/apb_initiator.sv
// Single-outstanding APB master: turns a valid/ready request into an APB SETUP/ACCESS
// transfer and returns a registered response, with an optional ACCESS-phase timeout.
module apb_initiator #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic         clk_i,
    input  logic         rst_i,
    apb_initiator_if.master bus
);
    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CNT_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      req_ready_q, req_ready_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;

    // Next state plus next value of every registered output
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    paddr_d  = bus.req_addr_i;
                    pwrite_d = bus.req_write_i;
                    pwdata_d = bus.req_wdata_i;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.pready_i) begin
                    rsp_err_d   = bus.pslverr_i;
                    rsp_rdata_d = (!pwrite_q && !bus.pslverr_i) ? bus.prdata_i : '0;
                    state_d     = RESP;
                end else if (TO_EN && (cnt_q == CNT_W'(CNT_LIMIT))) begin
                    // Hung slave: complete with an error instead of waiting forever
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake/strobe outputs follow the state being entered
        req_ready_d = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.psel_o      = psel_q;
    assign bus.penable_o   = penable_q;
    assign bus.pwrite_o    = pwrite_q;
    assign bus.paddr_o     = paddr_q;
    assign bus.pwdata_o    = pwdata_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transfer-level model.
module tb_apb_initiator;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_initiator_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

    apb_initiator #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: a transfer is either in flight (m_busy, m_acc ACCESS cycles so far,
    // 0 while still in SETUP) or awaiting consumption (m_resp).
    logic          m_busy = 1'b0;
    logic          m_resp = 1'b0;
    int            m_acc  = 0;
    logic          m_write = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_busy = 1'b0; m_resp = 1'b0; m_acc = 0;
            m_write = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
        end else if (m_resp) begin
            if (bus.rsp_ready_i) m_resp = 1'b0;
        end else if (m_busy) begin
            if (m_acc == 0) begin
                m_acc = 1;
            end else if (bus.pready_i) begin
                m_busy  = 1'b0;
                m_resp  = 1'b1;
                m_err   = bus.pslverr_i;
                m_rdata = (m_write || bus.pslverr_i) ? '0 : bus.prdata_i;
            end else if (TO != 0 && m_acc == int'(TO)) begin
                m_busy  = 1'b0;
                m_resp  = 1'b1;
                m_err   = 1'b1;
                m_rdata = '0;
            end else begin
                m_acc++;
            end
        end else if (bus.req_valid_i) begin
            m_busy  = 1'b1;
            m_acc   = 0;
            m_addr  = bus.req_addr_i;
            m_write = bus.req_write_i;
            m_wdata = bus.req_wdata_i;
        end
    endtask

    task automatic compare_all();
        chk("req_ready", 64'(bus.req_ready_o), 64'(!m_busy && !m_resp));
        chk("psel",      64'(bus.psel_o),      64'(m_busy));
        chk("penable",   64'(bus.penable_o),   64'(m_busy && m_acc > 0));
        chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(m_resp));
        chk("paddr",     64'(bus.paddr_o),     64'(m_addr));
        chk("pwrite",    64'(bus.pwrite_o),    64'(m_write));
        chk("pwdata",    64'(bus.pwdata_o),    64'(m_wdata));
        if (m_resp) begin
            chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(m_rdata));
            chk("rsp_err",   64'(bus.rsp_err_o),   64'(m_err));
        end
    endtask

    // One clock: DUT and model advance on the edge, outputs checked at the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic quiet();
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_write_i = 1'b0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
    endtask

    task automatic request(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_write_i = w;
        bus.req_wdata_i = d;
    endtask

    int waits;

    initial begin
        quiet();
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("rst_psel",      64'(bus.psel_o),      64'd0);
        chk("rst_paddr",     64'(bus.paddr_o),     64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        rst = 1'b0;
        cycle();

        // Read, zero wait
        request(32'h1A10_0004, 1'b0, 32'h0);
        bus.prdata_i = 32'hDEAD_BEEF;
        bus.pready_i = 1'b1;
        cycle();
        bus.req_valid_i = 1'b0;
        chk("rd_setup_psel",    64'(bus.psel_o),    64'd1);
        chk("rd_setup_penable", 64'(bus.penable_o), 64'd0);
        cycle();
        chk("rd_access_penable", 64'(bus.penable_o), 64'd1);
        cycle();
        chk("rd_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("rd_rdata",     64'(bus.rsp_rdata_o), 64'hDEAD_BEEF);
        chk("rd_err",       64'(bus.rsp_err_o),   64'd0);
        chk("rd_psel_off",  64'(bus.psel_o),      64'd0);
        bus.rsp_ready_i = 1'b1;
        cycle();
        chk("rd_back_idle", 64'(bus.req_ready_o), 64'd1);

        // Write with 3 wait states
        quiet();
        request(32'h1A10_1000, 1'b1, 32'h0000_00FF);
        bus.prdata_i = 32'h5555_AAAA;
        cycle();
        bus.req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("wr_wait_paddr",  64'(bus.paddr_o),  64'h1A10_1000);
        chk("wr_wait_pwdata", 64'(bus.pwdata_o), 64'h0000_00FF);
        bus.pready_i = 1'b1;
        cycle();
        cycle();
        chk("wr_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("wr_rdata",     64'(bus.rsp_rdata_o), 64'd0);
        chk("wr_err",       64'(bus.rsp_err_o),   64'd0);
        bus.rsp_ready_i = 1'b1;
        cycle();

        // Slave error on a read
        quiet();
        request(32'h1A10_0008, 1'b0, 32'h0);
        bus.prdata_i  = 32'h1234_5678;
        bus.pready_i  = 1'b1;
        bus.pslverr_i = 1'b1;
        cycle();
        bus.req_valid_i = 1'b0;
        cycle();
        cycle();
        chk("serr_err",   64'(bus.rsp_err_o),   64'd1);
        chk("serr_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        bus.rsp_ready_i = 1'b1;
        cycle();

        // Timeout with pready stuck low
        quiet();
        request(32'h1A10_2000, 1'b0, 32'h0);
        bus.prdata_i = 32'hFFFF_FFFF;
        cycle();
        bus.req_valid_i = 1'b0;
        waits = 0;
        for (int k = 0; k < 50 && !bus.rsp_valid_o; k++) begin
            if (bus.penable_o) waits++;
            cycle();
        end
        chk("to_access_cycles", 64'(waits), 64'd8);
        chk("to_rsp_valid",     64'(bus.rsp_valid_o), 64'd1);
        chk("to_err",           64'(bus.rsp_err_o),   64'd1);
        chk("to_rdata",         64'(bus.rsp_rdata_o), 64'd0);
        chk("to_psel",          64'(bus.psel_o),      64'd0);
        bus.rsp_ready_i = 1'b1;
        cycle();

        // pready arrives in the 8th ACCESS cycle: normal completion
        quiet();
        request(32'h1A10_2004, 1'b0, 32'h0);
        bus.prdata_i = 32'h0BAD_F00D;
        cycle();
        bus.req_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("late_in_access", 64'(bus.penable_o), 64'd1);
        bus.pready_i = 1'b1;
        cycle();
        chk("late_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("late_err",       64'(bus.rsp_err_o),   64'd0);
        chk("late_rdata",     64'(bus.rsp_rdata_o), 64'h0BAD_F00D);
        bus.rsp_ready_i = 1'b1;
        cycle();

        // Backpressure with a second request waiting
        quiet();
        request(32'h1A10_3000, 1'b0, 32'h0);
        bus.prdata_i = 32'h1357_9BDF;
        bus.pready_i = 1'b1;
        cycle();
        request(32'h1A10_3004, 1'b1, 32'hCAFE_F00D);
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
            chk("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
            chk("bp_rdata",     64'(bus.rsp_rdata_o), 64'h1357_9BDF);
            cycle();
        end
        bus.rsp_ready_i = 1'b1;
        cycle();
        chk("bp_idle_psel", 64'(bus.psel_o), 64'd0);
        cycle();
        bus.req_valid_i = 1'b0;
        chk("bp_second_setup", 64'(bus.psel_o),  64'd1);
        chk("bp_second_addr",  64'(bus.paddr_o), 64'h1A10_3004);
        cycle();
        cycle();
        chk("bp_second_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        cycle();

        // Reset during a waited ACCESS
        quiet();
        request(32'h1A10_4000, 1'b0, 32'h0);
        cycle();
        bus.req_valid_i = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("mrst_psel",      64'(bus.psel_o),      64'd0);
        chk("mrst_penable",   64'(bus.penable_o),   64'd0);
        chk("mrst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("mrst_paddr",     64'(bus.paddr_o),     64'd0);
        chk("mrst_req_ready", 64'(bus.req_ready_o), 64'd1);
        rst = 1'b0;
        bus.pready_i = 1'b1;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("mrst_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
        end

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            bus.req_valid_i = ($urandom_range(0, 2) != 0);
            bus.req_addr_i  = AW'($urandom);
            bus.req_write_i = 1'($urandom);
            bus.req_wdata_i = DW'($urandom);
            bus.prdata_i    = DW'($urandom);
            bus.pready_i    = ($urandom_range(0, 3) == 0);
            bus.pslverr_i   = ($urandom_range(0, 4) == 0);
            bus.rsp_ready_i = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/apb_initiator.md
# apb_initiator

Single-outstanding APB master that converts a valid/ready request/response interface into APB SETUP/ACCESS transfers. It is the initiator end of the APB fabric: its APB master port drives the upstream slave port of an APB node, which fans the transfer out to peripherals. A configurable ACCESS-phase timeout completes hung transfers with an error.

## Interface
Parameters:
- APB_ADDR_WIDTH, 32, address width
- APB_DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before forced error completion; 0 disables the timeout

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_addr_i  in  APB_ADDR_WIDTH  request address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  APB_DATA_WIDTH  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o
- rsp_rdata_o  out  APB_DATA_WIDTH  read data; 0 for writes and errors
- rsp_err_o  out  1  pslverr_i or timeout
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- paddr_o  out  APB_ADDR_WIDTH  APB address
- pwdata_o  out  APB_DATA_WIDTH  APB write data
- prdata_i  in  APB_DATA_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

## Operation
- States: IDLE, SETUP, ACCESS, RESP, held in a registered state variable.
- IDLE:
  - req_ready_o=1; psel_o=penable_o=0.
  - On req_valid_i & req_ready_o, latch req_addr_i, req_write_i and req_wdata_i into the paddr_o, pwrite_o and pwdata_o registers, clear the timeout counter, and go to SETUP.
- SETUP:
  - psel_o=1, penable_o=0 for exactly one cycle, then go to ACCESS unconditionally.
  - pready_i and pslverr_i are ignored in this state.
- ACCESS:
  - psel_o=1 and penable_o=1.
  - If pready_i=1, capture rsp_err_o=pslverr_i. Capture rsp_rdata_o as follows:
    - read with pslverr_i=0: prdata_i;
    - write, or pslverr_i=1: 0.
  - After the capture, go to RESP.
  - If pready_i=0 and the timeout is enabled, increment the counter.
  - If the counter equals TIMEOUT_CYCLES-1 while pready_i=0, capture rsp_err_o=1 and rsp_rdata_o=0, and go to RESP.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- RESP:
  - rsp_valid_o=1; psel_o=penable_o=0; req_ready_o=0.
  - rsp_rdata_o and rsp_err_o are held stable until rsp_valid_o & rsp_ready_i, then go to IDLE.
- paddr_o, pwrite_o and pwdata_o are updated only on request accept. They are held through SETUP, ACCESS and RESP, and retain their last value in IDLE.
- Only one transfer is outstanding at a time. A new request is never accepted before the previous response is consumed.

## Timing
Reset:
- Reset (rst_i=1 at an edge) forces IDLE.
- After that edge all outputs are 0 except req_ready_o=1: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rsp_valid_o, rsp_rdata_o and rsp_err_o are all 0.
- Reset mid-transfer (SETUP, ACCESS or RESP) drops the transfer silently. No response is produced and psel_o is low on the next cycle.

Latency:
- Accept at edge N: SETUP during cycle N..N+1, ACCESS from N+1.
- With pready_i=1 in the first ACCESS cycle, rsp_valid_o=1 from edge N+2.
- Minimum period is 4 cycles per transfer when rsp_ready_i is held high: IDLE, SETUP, ACCESS, RESP.

Boundary conditions:
- Each ACCESS wait cycle with pready_i=0 adds one cycle of latency.
- With timeout enabled, ACCESS lasts at most TIMEOUT_CYCLES cycles.
- pready_i=1 in the same cycle the counter hits its limit is a normal completion: pslverr_i is used, not the timeout.
- TIMEOUT_CYCLES=1: the first ACCESS cycle without pready_i times out.
- TIMEOUT_CYCLES=0: ACCESS waits indefinitely.
- rsp_ready_i held low: RESP is held and req_ready_o stays 0; req_valid_i is ignored.
- APB rule: paddr_o, pwrite_o, pwdata_o and psel_o are stable from SETUP until the cycle pready_i=1 (or timeout).

## Test plan
- Read, zero wait:
  - Stimulus: request addr=0x1A10_0004, read; prdata_i=0xDEADBEEF; pready_i=1 in ACCESS.
  - Required: psel_o 1 for 2 cycles, penable_o 1 for 1 cycle, rsp_valid_o 2 cycles after accept with rdata=0xDEADBEEF, err=0.
- Write with 3 wait states:
  - Stimulus: addr=0x1A10_1000, wdata=0x0000_00FF, pready_i low for 3 ACCESS cycles.
  - Required: pwdata_o and paddr_o stable for all 5 APB cycles; response rdata=0, err=0.
- Slave error:
  - Stimulus: read with pslverr_i=1 and pready_i=1.
  - Required: rsp_err_o=1, rsp_rdata_o=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, pready_i tied 0.
  - Required: exactly 8 ACCESS cycles, then rsp_valid_o with err=1, rdata=0, psel_o=0. Repeat with pready_i=1 on the 8th cycle: normal completion, err=0.
- Backpressure and back-to-back:
  - Stimulus: rsp_ready_i low for 5 cycles while req_valid_i is held with a second request.
  - Required: response held stable, req_ready_o=0 throughout; second transfer's SETUP starts 2 cycles after the response handshake.
- Reset mid-ACCESS:
  - Stimulus: assert rst_i during a waited ACCESS.
  - Required: next cycle psel_o=penable_o=rsp_valid_o=0, paddr_o=0, req_ready_o=1; no response is ever issued.
